dec_38_stream: RTL and testbench

DEC_38_STREAM -- requirements
Module: dec_38_stream

---
 rtl/dec_38_stream.sv | 128 ++++++++++++
 tb/tb_dec_38_stream.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dec_38_stream.sv
// Small FIFO of 3-bit codes whose head is presented as an 8-bit one-hot word,
// with a sticky OR of every delivered word and a delivered-word counter.
module dec_38_stream #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2:0]                 in_code,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [7:0]                 out_onehot,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       clr,
    output logic [7:0]                 seen,
    output logic [7:0]                 xfer_cnt,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // 3-to-8 decode; unknown codes map to an all-zero word
    function automatic logic [7:0] decode_code(input logic [2:0] code);
        logic [7:0] oh;
        case (code)
            3'd0:    oh = 8'h01;
            3'd1:    oh = 8'h02;
            3'd2:    oh = 8'h04;
            3'd3:    oh = 8'h08;
            3'd4:    oh = 8'h10;
            3'd5:    oh = 8'h20;
            3'd6:    oh = 8'h40;
            3'd7:    oh = 8'h80;
            default: oh = 8'h00;
        endcase
        return oh;
    endfunction

    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    seen_q, seen_d;
    logic [7:0]    xfer_q, xfer_d;
    logic          rdy_en_q;
    logic          push_s;
    logic          pop_s;
    logic [7:0]    head_oh_s;

    // rdy_en_q holds in_ready low during reset and until the first clock edge after it
    assign in_ready   = rdy_en_q && (level_q != LW'(DEPTH));
    assign out_valid  = (level_q != {LW{1'b0}});
    assign head_oh_s  = decode_code(mem_q[rd_ptr_q]);
    assign out_onehot = out_valid ? head_oh_s : 8'h00;
    assign seen       = seen_q;
    assign xfer_cnt   = xfer_q;
    assign level      = level_q;
    assign push_s     = in_valid && in_ready;
    assign pop_s      = out_valid && out_ready;

    // next-state for pointers, occupancy and delivery statistics
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        seen_d   = seen_q;
        xfer_d   = xfer_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // clr restarts the statistics but still counts a word popped in the same cycle
        if (clr) begin
            seen_d = pop_s ? out_onehot : 8'h00;
            xfer_d = pop_s ? 8'd1 : 8'd0;
        end else if (pop_s) begin
            seen_d = seen_q | out_onehot;
            xfer_d = xfer_q + 8'd1;
        end else begin
            seen_d = seen_q;
            xfer_d = xfer_q;
        end
    end

    // state registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 3'd0;
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
            seen_q   <= 8'h00;
            xfer_q   <= 8'h00;
            rdy_en_q <= 1'b0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= in_code;
            end else begin
                mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            seen_q   <= seen_d;
            xfer_q   <= xfer_d;
            rdy_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dec_38_stream.sv
// Directed, table-driven bench for dec_38_stream (DEPTH=4) plus hand-written
// sequences for async reset, long streaming and clr corner cases.
module tb_dec_38_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] in_code;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_onehot;
    logic       out_valid;
    logic       out_ready;
    logic       clr;
    logic [7:0] seen;
    logic [7:0] xfer_cnt;
    logic [2:0] level;

    int total = 0;
    int bad   = 0;

    dec_38_stream #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_code    (in_code),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .clr        (clr),
        .seen       (seen),
        .xfer_cnt   (xfer_cnt),
        .level      (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] code;
        logic       iv;
        logic       ordy;
        logic       clr;
        logic [7:0] oh;
        logic       ov;
        logic       ir;
        logic [2:0] lvl;
        logic [7:0] seen;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pushes;
        int pops;
        int word_err;
        int cyc;

        // expectations in each row are the outputs before that row's clock edge
        //            code  iv    ordy  clr   oh     ov    ir    lvl   seen   cnt
        vecs[0]  = '{3'd5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h00, 8'd0};
        vecs[1]  = '{3'd0, 1'b0, 1'b1, 1'b0, 8'h20, 1'b1, 1'b1, 3'd1, 8'h00, 8'd0};
        vecs[2]  = '{3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h20, 8'd1};
        vecs[3]  = '{3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h20, 8'd1};
        vecs[4]  = '{3'd1, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1, 3'd1, 8'h20, 8'd1};
        vecs[5]  = '{3'd2, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1, 3'd2, 8'h20, 8'd1};
        vecs[6]  = '{3'd3, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1, 3'd3, 8'h20, 8'd1};
        vecs[7]  = '{3'd4, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 3'd4, 8'h20, 8'd1};
        vecs[8]  = '{3'd4, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 3'd4, 8'h20, 8'd1};
        vecs[9]  = '{3'd4, 1'b1, 1'b1, 1'b0, 8'h02, 1'b1, 1'b1, 3'd3, 8'h21, 8'd2};
        vecs[10] = '{3'd0, 1'b0, 1'b1, 1'b0, 8'h04, 1'b1, 1'b1, 3'd3, 8'h23, 8'd3};
        vecs[11] = '{3'd0, 1'b0, 1'b0, 1'b0, 8'h08, 1'b1, 1'b1, 3'd2, 8'h27, 8'd4};
        vecs[12] = '{3'd0, 1'b0, 1'b0, 1'b0, 8'h08, 1'b1, 1'b1, 3'd2, 8'h27, 8'd4};
        vecs[13] = '{3'd0, 1'b0, 1'b1, 1'b0, 8'h08, 1'b1, 1'b1, 3'd2, 8'h27, 8'd4};
        vecs[14] = '{3'd0, 1'b0, 1'b1, 1'b0, 8'h10, 1'b1, 1'b1, 3'd1, 8'h2F, 8'd5};
        vecs[15] = '{3'd6, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 3'd0, 8'h3F, 8'd6};
        vecs[16] = '{3'd7, 1'b1, 1'b1, 1'b1, 8'h40, 1'b1, 1'b1, 3'd1, 8'h00, 8'd0};
        vecs[17] = '{3'd0, 1'b0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1, 3'd1, 8'h40, 8'd1};
        vecs[18] = '{3'd0, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 3'd1, 8'h40, 8'd1};
        vecs[19] = '{3'd0, 1'b0, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 3'd1, 8'h00, 8'd0};
        vecs[20] = '{3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h80, 8'd1};

        rst_n     = 1'b0;
        in_code   = 3'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;

        #1;
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_onehot",    {24'd0, out_onehot}, 32'h00);
        chk("rst_level",     {29'd0, level}, 32'd0);
        chk("rst_seen",      {24'd0, seen}, 32'h00);
        chk("rst_cnt",       {24'd0, xfer_cnt}, 32'd0);

        #11;
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", {31'd0, in_ready}, 32'd0);
        tick();
        chk("ready_after_edge", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 21; i++) begin
            in_code   = vecs[i].code;
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            clr       = vecs[i].clr;
            #1;
            chk($sformatf("v%0d_onehot", i), {24'd0, out_onehot}, {24'd0, vecs[i].oh});
            chk($sformatf("v%0d_valid", i),  {31'd0, out_valid},  {31'd0, vecs[i].ov});
            chk($sformatf("v%0d_ready", i),  {31'd0, in_ready},   {31'd0, vecs[i].ir});
            chk($sformatf("v%0d_level", i),  {29'd0, level},      {29'd0, vecs[i].lvl});
            chk($sformatf("v%0d_seen", i),   {24'd0, seen},       {24'd0, vecs[i].seen});
            chk($sformatf("v%0d_cnt", i),    {24'd0, xfer_cnt},   {24'd0, vecs[i].cnt});
            tick();
        end
        clr = 1'b0;

        // two queued codes, then reset asserted between clock edges
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_code   = 3'd1;
        tick();
        in_code = 3'd2;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_level", {29'd0, level}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid",  {31'd0, out_valid}, 32'd0);
        chk("async_rst_level",  {29'd0, level}, 32'd0);
        chk("async_rst_seen",   {24'd0, seen}, 32'h00);
        chk("async_rst_cnt",    {24'd0, xfer_cnt}, 32'd0);
        chk("async_rst_onehot", {24'd0, out_onehot}, 32'h00);
        chk("async_rst_ready",  {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_rst_level", {29'd0, level}, 32'd0);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // 300 code-7 words streamed with the sink always ready
        pushes    = 0;
        pops      = 0;
        word_err  = 0;
        cyc       = 0;
        in_code   = 3'd7;
        out_ready = 1'b1;
        while ((pushes < 300 || level != 3'd0) && cyc < 2000) begin
            in_valid = (pushes < 300);
            if (in_valid && in_ready) pushes++;
            if (out_valid && out_ready) begin
                pops++;
                if (out_onehot !== 8'h80) word_err++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_no_timeout", {31'd0, (cyc < 2000)}, 32'd1);
        chk("stream_pushes", pushes, 32'd300);
        chk("stream_pops", pops, 32'd300);
        chk("stream_word_errs", word_err, 32'd0);
        chk("stream_cnt_wrap", {24'd0, xfer_cnt}, 32'd44);
        chk("stream_seen", {24'd0, seen}, 32'h80);

        // clr coinciding with a pop of code 6, then clr with nothing popped
        in_valid  = 1'b1;
        in_code   = 3'd6;
        out_ready = 1'b0;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr       = 1'b1;
        tick();
        chk("clr_pop_seen", {24'd0, seen}, 32'h40);
        chk("clr_pop_cnt",  {24'd0, xfer_cnt}, 32'd1);
        in_valid  = 1'b1;
        in_code   = 3'd3;
        out_ready = 1'b0;
        clr       = 1'b0;
        tick();
        in_valid = 1'b0;
        clr      = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_only_seen",  {24'd0, seen}, 32'h00);
        chk("clr_only_cnt",   {24'd0, xfer_cnt}, 32'd0);
        chk("clr_only_level", {29'd0, level}, 32'd1);
        chk("clr_only_head",  {24'd0, out_onehot}, 32'h08);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
